// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
// Module      : keypad_pkg
// Description : Shared types and helpers for the matrix keypad scanner.
//               key_w()  - key index width, $clog2 of key count, minimum 1.
//               evt_t    - {press, key} event record carried to the consumer.
//               EVT_W    - packed width of evt_t (FIFO / holding word width).
//               KEY_W_MAX bounds the key field; matrices up to 2**16 keys.
// Revision    : 1.0 - initial release
// ============================================================================
package keypad_pkg;

    localparam int KEY_W_MAX = 16;

    typedef struct packed {
        logic                 press;
        logic [KEY_W_MAX-1:0] key;
    } evt_t;

    localparam int EVT_W = $bits(evt_t);

    function automatic int key_w(input int n_keys);
        return (n_keys <= 2) ? 1 : $clog2(n_keys);
    endfunction

endpackage : keypad_pkg
`default_nettype wire

// File: rtl/keypad_evt_fifo.sv
`default_nettype none
// ============================================================================
// Module      : keypad_evt_fifo
// Description : Synchronous FIFO with valid/ready on both sides. A write is
//               accepted while full if the head is popped in the same cycle.
//               Head data reads as zero while empty so the outputs are clean
//               out of reset.
// Ports       : clk, rst_n (async, active-low)
//               i_wr_valid / o_wr_ready / i_wr_data  - write side
//               o_rd_valid / i_rd_ready / o_rd_data  - read side (head)
// Parameters  : WIDTH - word width; DEPTH - entries, power of 2, >= 2
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_evt_fifo
    import keypad_pkg::*;
#(
    parameter int WIDTH = EVT_W,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_wr_valid,
    output logic             o_wr_ready,
    input  logic [WIDTH-1:0] i_wr_data,
    output logic             o_rd_valid,
    input  logic             i_rd_ready,
    output logic [WIDTH-1:0] o_rd_data
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_full;
    logic             w_wr;
    logic             w_rd;

    assign w_full     = (r_count == (AW+1)'(DEPTH));
    assign o_rd_valid = (r_count != '0);
    assign o_wr_ready = !w_full || i_rd_ready;
    assign w_wr       = i_wr_valid && o_wr_ready;
    assign w_rd       = o_rd_valid && i_rd_ready;
    assign o_rd_data  = o_rd_valid ? r_mem[r_rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of 2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : keypad_evt_fifo
`default_nettype wire

// File: rtl/keypad_matrix_scanner.sv
`default_nettype none
// ============================================================================
// Module      : keypad_matrix_scanner
// Description : Row-scan matrix keypad controller. Drives one-hot rows, samples
//               the columns on the last dwell cycle of each row, debounces whole
//               frames and reports key changes as a press/release event stream.
// Ports       : clk, rst_n (async, active-low), en (scan enable)
//               row_o [ROWS]       - one-hot row drive (0 while en=0)
//               col_i [COLS]       - column sense
//               keys  [ROWS*COLS]  - debounced bitmap, bit r*COLS+c
//               evt_valid/evt_ready/evt_press/evt_key - event stream
// Config      : KEYPAD_EVT_FIFO_EN - event sink is an EVT_DEPTH-entry FIFO;
//               otherwise a single holding register.
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_matrix_scanner
    import keypad_pkg::*;
#(
    parameter  int ROWS            = 4,
    parameter  int COLS            = 3,
    parameter  int SCAN_DIV        = 4,
    parameter  int DEBOUNCE_FRAMES = 20,
    parameter  int EVT_DEPTH       = 4,
    localparam int NKEYS           = ROWS * COLS,
    localparam int KEY_W           = key_w(NKEYS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [ROWS-1:0]  row_o,
    input  logic [COLS-1:0]  col_i,
    output logic [NKEYS-1:0] keys,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic             evt_press,
    output logic [KEY_W-1:0] evt_key
);

    localparam int RW = $clog2(ROWS);
    localparam int DW = $clog2(SCAN_DIV);

    if (ROWS < 2 || COLS < 1 || SCAN_DIV < 2 || DEBOUNCE_FRAMES < 1 ||
        DEBOUNCE_FRAMES > 255 || EVT_DEPTH < 2 ||
        (EVT_DEPTH & (EVT_DEPTH - 1)) != 0 || KEY_W > KEY_W_MAX) begin : g_bad_params
        $error("keypad_matrix_scanner: illegal parameter combination");
    end

    logic [RW-1:0]    r_row;
    logic [DW-1:0]    r_dwell;
    logic [NKEYS-1:0] r_frame;
    logic [NKEYS-1:0] r_prev;
    logic [NKEYS-1:0] r_keys;
    logic [NKEYS-1:0] r_pending;
    logic [7:0]       r_stable_cnt;

    logic             w_sample;
    logic             w_frame_end;
    logic             w_commit;
    logic [NKEYS-1:0] w_frame_new;
    logic             w_space;
    logic             w_emit;
    logic [KEY_W-1:0] w_idx;
    logic [NKEYS-1:0] w_emit_mask;
    evt_t             w_evt;
    evt_t             w_head;
    logic             w_out_valid;
    logic             w_unused_head;

    function automatic logic [KEY_W-1:0] lowest_set(input logic [NKEYS-1:0] v);
        lowest_set = '0;
        for (int i = NKEYS - 1; i >= 0; i--) begin
            if (v[i]) lowest_set = KEY_W'(i);
        end
    endfunction

    // ------------------------------------------------------------------ scan
    assign w_sample    = en && (r_dwell == DW'(SCAN_DIV - 1));
    assign w_frame_end = w_sample && (r_row == RW'(ROWS - 1));

    always_comb begin
        w_frame_new = r_frame;
        w_frame_new[r_row*COLS +: COLS] = col_i;
    end

    always_comb begin
        row_o = '0;
        if (en) row_o[r_row] = 1'b1;
    end

    // While disabled the position is parked at row 0 / dwell 0: nothing sees
    // it (rows are not driven) and scanning must restart there anyway. Any
    // partial frame is overwritten row by row before the next frame end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row   <= '0;
            r_dwell <= '0;
            r_frame <= '0;
        end else if (!en) begin
            r_row   <= '0;
            r_dwell <= '0;
        end else if (w_sample) begin
            r_dwell <= '0;
            r_frame <= w_frame_new;
            r_row   <= (r_row == RW'(ROWS - 1)) ? '0 : r_row + RW'(1);
        end else begin
            r_dwell <= r_dwell + DW'(1);
        end
    end

    // -------------------------------------------------------------- debounce
    assign w_commit = w_frame_end && (w_frame_new == r_prev) &&
                      (r_stable_cnt == 8'(DEBOUNCE_FRAMES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev       <= '0;
            r_stable_cnt <= '0;
            r_keys       <= '0;
        end else begin
            if (w_frame_end) begin
                r_prev <= w_frame_new;
                if (w_frame_new != r_prev || w_commit) r_stable_cnt <= '0;
                else                                   r_stable_cnt <= r_stable_cnt + 8'd1;
            end
            if (w_commit) r_keys <= w_frame_new;
        end
    end

    assign keys = r_keys;

    // --------------------------------------------------------------- emitter
    assign w_idx       = lowest_set(r_pending);
    assign w_emit      = w_space && (r_pending != '0);
    assign w_emit_mask = w_emit ? (NKEYS'(1) << w_idx) : '0;

    always_comb begin
        w_evt       = '0;
        w_evt.press = r_keys[w_idx];
        w_evt.key   = KEY_W_MAX'(w_idx);
    end

    // Clear the emitted bit first, then fold in the commit delta, so a key
    // that changes again in the emission cycle is re-flagged, and a change
    // undone before emission cancels out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_emit_mask) ^
                         (w_commit ? (r_keys ^ w_frame_new) : '0);
        end
    end

    // ------------------------------------------------------------------ sink
`ifdef KEYPAD_EVT_FIFO_EN
    logic             w_fifo_wr_ready;
    logic             w_fifo_rd_valid;
    logic [EVT_W-1:0] w_fifo_rd_data;

    keypad_evt_fifo #(
        .WIDTH (EVT_W),
        .DEPTH (EVT_DEPTH)
    ) u_evt_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_wr_valid (w_emit),
        .o_wr_ready (w_fifo_wr_ready),
        .i_wr_data  (w_evt),
        .o_rd_valid (w_fifo_rd_valid),
        .i_rd_ready (evt_ready),
        .o_rd_data  (w_fifo_rd_data)
    );

    assign w_space     = w_fifo_wr_ready;
    assign w_head      = evt_t'(w_fifo_rd_data);
    assign w_out_valid = w_fifo_rd_valid;
`else
    evt_t r_out_evt;
    logic r_out_valid;

    // Loaded when empty or being popped; otherwise held so data stays stable
    // under backpressure.
    assign w_space = !r_out_valid || evt_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_evt   <= '0;
        end else if (w_emit) begin
            r_out_valid <= 1'b1;
            r_out_evt   <= w_evt;
        end else if (evt_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign w_head      = r_out_evt;
    assign w_out_valid = r_out_valid;
`endif

    assign evt_valid     = w_out_valid;
    assign evt_press     = w_head.press;
    assign evt_key       = w_head.key[KEY_W-1:0];
    assign w_unused_head = ^w_head;

endmodule : keypad_matrix_scanner
`default_nettype wire
